crossdomain_data_tx: RTL and testbench

Single-clock transmit front-end for the crossdomain_data bridge, on the source (clk_a) side. It queues words from a local producer in a small FIFO and issues one word at a time as a single-cycle strobe. It holds each word stable on the bridge data bus until the returning done pulse arrives or a timeout expires. This guarantees the bridge's free-running destination-side sampler only ever sees settled data.

---
 rtl/crossdomain_data_tx_pkg.sv | 14 +
 rtl/crossdomain_tx_fifo.sv | 67 ++++++
 rtl/crossdomain_data_tx.sv | 114 +++++++++++
 tb/tb_crossdomain_data_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossdomain_data_tx_pkg.sv
// Shared types for the crossdomain_data transmit front-end: FSM state encoding
// and FIFO sizing helper.
package crossdomain_data_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } tx_state_e;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/crossdomain_tx_fifo.sv
// Small synchronous FIFO feeding the transmit FSM. A push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module crossdomain_tx_fifo
  import crossdomain_data_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      count
);

  localparam int               DEPTH    = fifo_depth(FIFO_AW);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/crossdomain_data_tx.sv
// Transmit front-end on the clk_a side of the crossdomain_data bridge: queues
// producer words and holds each on xd_data from strobe until done or timeout.
module crossdomain_data_tx
  import crossdomain_data_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_stb,
  output logic                  in_full,
  output logic                  in_overflow,
  output logic [DATA_WIDTH-1:0] xd_data,
  output logic                  xd_stb,
  input  logic                  xd_done,
  output logic                  idle,
  output logic                  timeout_err
);

  localparam int               DEPTH    = fifo_depth(FIFO_AW);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] xd_data_q, xd_data_d;
  logic                  xd_stb_q, xd_stb_d;
  logic                  ovf_q, ovf_d;
  logic                  tmo_q, tmo_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [FIFO_AW:0]      fifo_count;

  crossdomain_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xd_data_d = xd_data_q;
    xd_stb_d  = 1'b0;
    tmo_d     = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          xd_data_d = fifo_head;
          xd_stb_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (xd_done) begin
          state_d = ST_IDLE;
        end else if (TMO_EN && cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fifo_push = in_stb && (!fifo_full || fifo_pop);
    ovf_d     = in_stb && !fifo_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      xd_data_q <= '0;
      xd_stb_q  <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xd_data_q <= xd_data_d;
      xd_stb_q  <= xd_stb_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign xd_data     = xd_data_q;
  assign xd_stb      = xd_stb_q;
  assign in_overflow = ovf_q;
  assign timeout_err = tmo_q;
  assign in_full     = (fifo_count == FULL_CNT);
  assign idle        = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_crossdomain_data_tx.sv
// Bench for crossdomain_data_tx: two instances (timeout 8 and timeout disabled)
// share one stimulus stream and are compared every cycle to a queue-based model.
module tb_crossdomain_data_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_stb = 1'b0;
  logic        xd_done = 1'b0;

  // index 0: TIMEOUT_CYCLES=8, index 1: timeout disabled
  logic [31:0] xd_data_o [2];
  logic        xd_stb_o [2];
  logic        in_full_o [2];
  logic        in_ovf_o [2];
  logic        idle_o [2];
  logic        tmo_o [2];

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  crossdomain_data_tx #(.DATA_WIDTH(32), .FIFO_AW(2), .TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .reset(reset), .in_data(in_data), .in_stb(in_stb),
    .in_full(in_full_o[0]), .in_overflow(in_ovf_o[0]), .xd_data(xd_data_o[0]),
    .xd_stb(xd_stb_o[0]), .xd_done(xd_done), .idle(idle_o[0]), .timeout_err(tmo_o[0]));

  crossdomain_data_tx #(.DATA_WIDTH(32), .FIFO_AW(2), .TIMEOUT_CYCLES(0)) dut_n (
    .clk(clk), .reset(reset), .in_data(in_data), .in_stb(in_stb),
    .in_full(in_full_o[1]), .in_overflow(in_ovf_o[1]), .xd_data(xd_data_o[1]),
    .xd_stb(xd_stb_o[1]), .xd_done(xd_done), .idle(idle_o[1]), .timeout_err(tmo_o[1]));

  // Reference model: a queue of pending words, a busy flag for the word in
  // flight and the number of cycles it has waited.
  logic [31:0] mq [2][$];
  bit          m_busy [2] = '{0, 0};
  int          m_wait [2] = '{0, 0};
  logic [31:0] e_data [2] = '{32'h0, 32'h0};
  logic        e_stb [2]  = '{1'b0, 1'b0};
  logic        e_ovf [2]  = '{1'b0, 1'b0};
  logic        e_tmo [2]  = '{1'b0, 1'b0};

  function automatic int tmo_limit(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  task automatic model_step(input int k);
    bit pop, drop;
    pop  = !m_busy[k] && (mq[k].size() != 0);
    drop = in_stb && (mq[k].size() == DEPTH) && !pop;
    e_stb[k] = 1'b0;
    e_tmo[k] = 1'b0;
    e_ovf[k] = drop;
    if (m_busy[k]) begin
      if (xd_done) m_busy[k] = 0;
      else if (tmo_limit(k) != 0 && m_wait[k] + 1 == tmo_limit(k)) begin
        e_tmo[k]  = 1'b1;
        m_busy[k] = 0;
      end else m_wait[k]++;
    end else if (pop) begin
      e_data[k] = mq[k].pop_front();
      e_stb[k]  = 1'b1;
      m_busy[k] = 1;
      m_wait[k] = 0;
    end
    if (in_stb && !drop) mq[k].push_back(in_data);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_busy[k] = 0;
        m_wait[k] = 0;
        e_data[k] = '0;
        e_stb[k]  = 1'b0;
        e_ovf[k]  = 1'b0;
        e_tmo[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = (k == 0) ? "t" : "n";
      chk({"xd_data_", s}, xd_data_o[k], e_data[k]);
      chk({"xd_stb_", s}, 32'(xd_stb_o[k]), 32'(e_stb[k]));
      chk({"in_overflow_", s}, 32'(in_ovf_o[k]), 32'(e_ovf[k]));
      chk({"timeout_err_", s}, 32'(tmo_o[k]), 32'(e_tmo[k]));
      chk({"in_full_", s}, 32'(in_full_o[k]), 32'(mq[k].size() == DEPTH));
      chk({"idle_", s}, 32'(idle_o[k]), 32'(!m_busy[k] && mq[k].size() == 0));
    end
  endtask

  // Drive inputs just after a falling edge, then check after the next one.
  task automatic tick(input logic s, input logic [31:0] d, input logic dn);
    in_stb  = s;
    in_data = d;
    xd_done = dn;
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(idle_o[0] && idle_o[1]) && n < 60) begin
      tick(1'b0, 32'h0, 1'b1);
      n++;
    end
    tick(1'b0, 32'h0, 1'b0);
    chk("drain_bound", 32'(n < 60), 32'd1);
  endtask

  // Release the word in flight on the untimed instance and expect w next.
  task automatic deliver(input string tag, input logic [31:0] w);
    int n;
    tick(1'b0, 32'h0, 1'b1);
    n = 0;
    while (xd_stb_o[1] !== 1'b1 && n < 12) begin
      tick(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk({tag, "_seen"}, 32'(xd_stb_o[1]), 32'd1);
    chk({tag, "_data"}, xd_data_o[1], w);
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_data"}, xd_data_o[k], 32'h0);
      chk({tag, "_stb"}, 32'(xd_stb_o[k]), 32'd0);
      chk({tag, "_ovf"}, 32'(in_ovf_o[k]), 32'd0);
      chk({tag, "_tmo"}, 32'(tmo_o[k]), 32'd0);
      chk({tag, "_full"}, 32'(in_full_o[k]), 32'd0);
      chk({tag, "_idle"}, 32'(idle_o[k]), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset_checks("rst");
    reset = 1'b0;
    tick(1'b0, 32'h0, 1'b0);

    // single word: strobe two cycles after the write, data held until done
    tick(1'b1, 32'hDEADBEEF, 1'b0);
    chk("t1_stb_early", 32'(xd_stb_o[1]), 32'd0);
    tick(1'b0, 32'h0, 1'b0);
    chk("t1_stb", 32'(xd_stb_o[1]), 32'd1);
    chk("t1_data", xd_data_o[1], 32'hDEADBEEF);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      chk("t1_stb_once", 32'(xd_stb_o[1]), 32'd0);
      chk("t1_hold", xd_data_o[1], 32'hDEADBEEF);
    end
    tick(1'b0, 32'h0, 1'b1);
    chk("t1_idle", 32'(idle_o[1]), 32'd1);
    chk("t1_hold_end", xd_data_o[1], 32'hDEADBEEF);
    drain();

    // burst of six with done withheld: word 6 dropped, order 1..5
    for (int w = 1; w <= 6; w++) begin
      tick(1'b1, 32'(w), 1'b0);
      if (w == 2) chk("burst_w1", xd_data_o[1], 32'd1);
    end
    chk("burst_full", 32'(in_full_o[1]), 32'd1);
    chk("burst_ovf", 32'(in_ovf_o[1]), 32'd1);
    tick(1'b0, 32'h0, 1'b0);
    chk("burst_ovf_pulse", 32'(in_ovf_o[1]), 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0);
    for (int w = 2; w <= 5; w++) deliver("burst", 32'(w));
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b0);
    chk("burst_no6", 32'(xd_stb_o[1]), 32'd0);
    chk("burst_idle", 32'(idle_o[1]), 32'd1);
    drain();

    // timeout after 8 WAIT cycles, then a late done must be harmless
    tick(1'b1, 32'h55, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    chk("tmo_stb", 32'(xd_stb_o[0]), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      chk("tmo_early", 32'(tmo_o[0]), 32'd0);
    end
    tick(1'b0, 32'h0, 1'b0);
    chk("tmo_pulse", 32'(tmo_o[0]), 32'd1);
    chk("tmo_idle", 32'(idle_o[0]), 32'd1);
    tick(1'b1, 32'h66, 1'b1);
    chk("tmo_once", 32'(tmo_o[0]), 32'd0);
    tick(1'b0, 32'h0, 1'b0);
    chk("tmo_next_stb", 32'(xd_stb_o[0]), 32'd1);
    chk("tmo_next_data", xd_data_o[0], 32'h66);
    tick(1'b0, 32'h0, 1'b1);
    drain();

    // done in the last timeout cycle wins
    tick(1'b1, 32'h99, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 7; i++) tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    chk("coll_no_tmo", 32'(tmo_o[0]), 32'd0);
    chk("coll_idle", 32'(idle_o[0]), 32'd1);
    tick(1'b0, 32'h0, 1'b0);
    chk("coll_no_tmo2", 32'(tmo_o[0]), 32'd0);
    drain();

    // push and pop together on a full FIFO
    for (int w = 0; w < 5; w++) tick(1'b1, 32'h10 + 32'(w), 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    chk("pp_full", 32'(in_full_o[1]), 32'd1);
    tick(1'b1, 32'hA, 1'b0);
    chk("pp_no_ovf", 32'(in_ovf_o[1]), 32'd0);
    chk("pp_still_full", 32'(in_full_o[1]), 32'd1);
    chk("pp_head", xd_data_o[1], 32'h11);
    deliver("pp", 32'h12);
    deliver("pp", 32'h13);
    deliver("pp", 32'h14);
    deliver("pp_last", 32'hA);
    tick(1'b0, 32'h0, 1'b1);
    drain();

    // reset while waiting with two words queued
    tick(1'b1, 32'h77, 1'b0);
    tick(1'b1, 32'h1, 1'b0);
    chk("mid_wait_data", xd_data_o[1], 32'h77);
    tick(1'b1, 32'h2, 1'b0);
    in_stb = 1'b0;
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    @(negedge clk);
    check_all();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b1);
      chk("midrst_no_stb", 32'(xd_stb_o[0] | xd_stb_o[1]), 32'd0);
      chk("midrst_idle", 32'(idle_o[0] & idle_o[1]), 32'd1);
    end

    // randomized traffic with occasional resets and spurious done pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        check_all();
        reset = 1'b0;
      end else begin
        tick(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
